// File: rtl/iface_route_ctrl_if.sv
// FIFO-side and destination-side signals of the input-FIFO route sequencer.
// The sequencer side uses master; the FIFO/scratch-pad side uses slave.
interface iface_route_ctrl_if #(
    parameter int FIFO_WIDTH = 64
);
    logic                  fifo_empty;
    logic [FIFO_WIDTH-1:0] fifo_dout;
    logic                  fifo_rd_en;
    logic [2:0]            dst_full;
    logic [1:0]            demux_sel;
    logic [2:0]            dst_wr_en;

    modport master (
        input  fifo_empty, fifo_dout, dst_full,
        output fifo_rd_en, demux_sel, dst_wr_en
    );

    modport slave (
        output fifo_empty, fifo_dout, dst_full,
        input  fifo_rd_en, demux_sel, dst_wr_en
    );
endinterface

// File: rtl/iface_route_ctrl.sv
// Pops header-framed packets from an FWFT FIFO and steers the payload to the
// filter / ifmap / psum scratch-pad write paths through the 3-way demux.
module iface_route_ctrl #(
    parameter int FIFO_WIDTH = 64,
    parameter int LEN_W      = 14
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 clr_err,
    iface_route_ctrl_if.master   bus,
    output logic                 busy,
    output logic                 pkt_done,
    output logic                 err,
    output logic [15:0]          words_sent
);
    typedef enum logic [1:0] {IDLE, PAYLOAD, DRAIN} state_t;

    // Demux code that selects each destination write-enable bit.
    localparam logic [1:0] DEST_CODE [3] = '{2'b00, 2'b10, 2'b01};

    state_t                  state_reg, state_next;
    logic [1:0]              sel_reg, sel_next;
    logic [LEN_W-1:0]        remaining_reg, remaining_next;
    logic                    done_reg, done_next;
    logic                    err_reg;
    logic [15:0]             words_reg;

    logic [FIFO_WIDTH-1:0]   head;
    logic [1:0]              hdr_code;
    logic [LEN_W-1:0]        hdr_len;
    logic                    unused_hdr_bits;
    logic [2:0]              dest_onehot;
    logic                    pop, err_set, count_inc;
    logic [2:0]              wr_en;

    assign head            = bus.fifo_dout;
    assign hdr_code        = head[1:0];
    assign hdr_len         = head[LEN_W+1:2];
    assign unused_hdr_bits = ^head[FIFO_WIDTH-1:LEN_W+2];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dest
            assign dest_onehot[gi] = (sel_reg == DEST_CODE[gi]);
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        sel_next       = sel_reg;
        remaining_next = remaining_reg;
        done_next      = 1'b0;
        err_set        = 1'b0;
        count_inc      = 1'b0;
        pop            = 1'b0;
        wr_en          = 3'b000;
        case (state_reg)
            IDLE: begin
                if (enable && !bus.fifo_empty) begin
                    pop            = 1'b1;
                    sel_next       = hdr_code;
                    remaining_next = hdr_len;
                    if (hdr_code == 2'b11) begin
                        err_set = 1'b1;
                        if (hdr_len != '0)
                            state_next = DRAIN;
                    end else if (hdr_len == '0) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (!bus.fifo_empty && ((dest_onehot & bus.dst_full) == 3'b000)) begin
                    pop            = 1'b1;
                    wr_en          = dest_onehot;
                    count_inc      = 1'b1;
                    remaining_next = remaining_reg - LEN_W'(1);
                    if (remaining_reg == LEN_W'(1)) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (!bus.fifo_empty) begin
                    pop            = 1'b1;
                    remaining_next = remaining_reg - LEN_W'(1);
                    if (remaining_reg == LEN_W'(1))
                        state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            sel_reg       <= 2'b00;
            remaining_reg <= '0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            words_reg     <= 16'd0;
        end else begin
            state_reg     <= state_next;
            sel_reg       <= sel_next;
            remaining_reg <= remaining_next;
            done_reg      <= done_next;
            if (err_set)
                err_reg <= 1'b1;
            else if (clr_err)
                err_reg <= 1'b0;
            if (count_inc && (words_reg != 16'hFFFF))
                words_reg <= words_reg + 16'd1;
        end
    end

    // Strobes are held off while reset is asserted, independent of state.
    assign bus.fifo_rd_en = rst_n & pop;
    assign bus.dst_wr_en  = rst_n ? wr_en : 3'b000;
    assign bus.demux_sel  = sel_reg;
    assign busy           = (state_reg != IDLE);
    assign pkt_done       = done_reg;
    assign err            = err_reg;
    assign words_sent     = words_reg;
endmodule

// File: tb/tb_iface_route_ctrl.sv
// Directed and randomized checks of iface_route_ctrl against a packet-level
// scoreboard: expected deliveries, completions and word counts per packet.
module tb_iface_route_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, enable, clr_err;
    logic        busy, pkt_done, err;
    logic [15:0] words_sent;

    iface_route_ctrl_if #(.FIFO_WIDTH(64)) bus ();

    iface_route_ctrl #(.FIFO_WIDTH(64), .LEN_W(14)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .clr_err    (clr_err),
        .bus        (bus.master),
        .busy       (busy),
        .pkt_done   (pkt_done),
        .err        (err),
        .words_sent (words_sent)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  dest;
        logic [1:0]  code;
        logic [63:0] word;
    } exp_t;

    logic [63:0] fifo_q [$];
    exp_t        exp_q [$];
    int          checks = 0, errors = 0;
    int          exp_done = 0, done_cnt = 0, exp_ws = 0;
    logic        exp_err = 1'b0;
    logic        rand_mode = 1'b0;
    logic [2:0]  full_drive = 3'b000;

    // Values seen in the last tick: c_* before the edge, r_* just after it.
    logic        c_rd, busy_b;
    logic [2:0]  c_wr;
    logic [1:0]  c_sel, r_sel;
    logic        r_done, r_err, r_busy;
    logic [15:0] r_ws;
    logic        tr_rd [16];
    logic [2:0]  tr_wr [16];
    logic        tr_done [16];
    int          tr_n = 0;

    int t2_wr [8]   = '{0, 2, 2, 2, 2, 0, 4, 4};
    int t2_done [8] = '{0, 0, 0, 0, 1, 0, 0, 1};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] dest_of(input logic [1:0] code);
        case (code)
            2'b00:   return 3'b001;
            2'b10:   return 3'b010;
            2'b01:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    task automatic push_packet(input logic [1:0] code, input int n);
        logic [63:0] w;
        w = {$urandom, $urandom};
        w[15:2] = 14'(n);
        w[1:0]  = code;
        fifo_q.push_back(w);
        for (int i = 0; i < n; i++) begin
            w = {$urandom, $urandom};
            fifo_q.push_back(w);
            if (code != 2'b11)
                exp_q.push_back('{dest_of(code), code, w});
        end
        if (code != 2'b11) begin
            exp_done++;
            exp_ws = (exp_ws + n > 65535) ? 65535 : exp_ws + n;
        end else begin
            exp_err = 1'b1;
        end
        $display("pkt code=%b len=%0d", code, n);
    endtask

    task automatic tick();
        logic hole;
        exp_t e;
        hole = rand_mode && ($urandom_range(0, 4) == 0);
        bus.fifo_empty = (fifo_q.size() == 0) || hole;
        bus.fifo_dout  = (fifo_q.size() != 0) ? fifo_q[0] : {$urandom, $urandom};
        if (rand_mode) begin
            bus.dst_full = {$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                            $urandom_range(0, 3) == 0};
            enable = ($urandom_range(0, 9) != 0);
        end else begin
            bus.dst_full = full_drive;
        end
        #1;
        c_rd   = bus.fifo_rd_en;
        c_wr   = bus.dst_wr_en;
        c_sel  = bus.demux_sel;
        busy_b = busy;
        if (!rst_n) begin
            check("rst_rd", c_rd, 0);
            check("rst_wr", c_wr, 0);
        end
        if (c_rd)
            check("rd_nonempty", bus.fifo_empty, 0);
        if (!enable && busy_b === 1'b0)
            check("en_gate", c_rd, 0);
        if (c_wr != 3'b000) begin
            check("wr_unfull", c_wr & bus.dst_full, 0);
            check("wr_pop", c_rd, 1);
            if (exp_q.size() == 0) begin
                check("wr_extra", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("wr_dest", c_wr, e.dest);
                check("wr_sel", c_sel, e.code);
                check("wr_word", bus.fifo_dout, e.word);
            end
        end
        @(posedge clk);
        if (c_rd && fifo_q.size() != 0)
            void'(fifo_q.pop_front());
        #1;
        r_done = pkt_done;
        r_err  = err;
        r_busy = busy;
        r_ws   = words_sent;
        r_sel  = bus.demux_sel;
        if (r_done === 1'b1)
            done_cnt++;
        if (tr_n < 16) begin
            tr_rd[tr_n]   = c_rd;
            tr_wr[tr_n]   = c_wr;
            tr_done[tr_n] = r_done;
            tr_n++;
        end
        @(negedge clk);
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((fifo_q.size() != 0 || r_busy !== 1'b0) && n < budget);
        check("drained", fifo_q.size(), 0);
        check("idle", r_busy, 0);
    endtask

    task automatic end_checks();
        check("exp_left", exp_q.size(), 0);
        check("done_cnt", done_cnt, exp_done);
        check("words_sent", r_ws, exp_ws);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b1; clr_err = 1'b0;
        bus.fifo_empty = 1'b1; bus.fifo_dout = '0; bus.dst_full = 3'b000;

        // Reset with a packet waiting, then the basic 3-word filter packet.
        push_packet(2'b00, 3);
        tick(); tick();
        check("rst_busy", r_busy, 0);
        check("rst_done", r_done, 0);
        check("rst_err", r_err, 0);
        check("rst_ws", r_ws, 0);
        check("rst_sel", r_sel, 0);
        rst_n = 1'b1;
        tr_n = 0;
        repeat (4) tick();
        check("t1_hdr_rd", tr_rd[0], 1);
        check("t1_hdr_wr", tr_wr[0], 0);
        for (int i = 1; i < 4; i++) check("t1_wr", tr_wr[i], 3'b001);
        check("t1_done_early", tr_done[2], 0);
        check("t1_done", tr_done[3], 1);
        check("t1_sel", r_sel, 2'b00);
        end_checks();

        // Back-to-back ifmap then psum packets, no bubble.
        push_packet(2'b10, 4);
        push_packet(2'b01, 2);
        tr_n = 0;
        repeat (8) tick();
        for (int i = 0; i < 8; i++) begin
            check("t2_rd", tr_rd[i], 1);
            check("t2_wr", tr_wr[i], t2_wr[i]);
            check("t2_done", tr_done[i], t2_done[i]);
        end
        end_checks();

        // psum packet stalled by dst_full[2]; other full bits must not stall.
        push_packet(2'b01, 5);
        tr_n = 0;
        repeat (3) tick();
        full_drive = 3'b100;
        repeat (3) begin
            tick();
            check("t3_stall_rd", c_rd, 0);
            check("t3_stall_wr", c_wr, 0);
            check("t3_stall_sel", r_sel, 2'b01);
        end
        full_drive = 3'b011;
        repeat (3) begin
            tick();
            check("t3_resume_wr", c_wr, 3'b100);
        end
        full_drive = 3'b000;
        check("t3_done", r_done, 1);
        end_checks();

        // Illegal code drains; set beats clear in the same cycle.
        push_packet(2'b11, 2);
        push_packet(2'b00, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("t4_err_set", r_err, 1);
        full_drive = 3'b111;
        repeat (2) begin
            tick();
            check("t4_drain_rd", c_rd, 1);
            check("t4_drain_wr", c_wr, 0);
            check("t4_drain_done", r_done, 0);
        end
        full_drive = 3'b000;
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("t4_err_clr", r_err, 0);
        tick();
        check("t4_wr", c_wr, 3'b001);
        check("t4_done", r_done, 1);
        end_checks();

        // Zero-length packets: legal completes at once, illegal only flags.
        push_packet(2'b00, 0);
        push_packet(2'b11, 0);
        tick();
        check("t5_rd", c_rd, 1);
        check("t5_wr", c_wr, 0);
        check("t5_done", r_done, 1);
        check("t5_busy", r_busy, 0);
        tick();
        check("t5_bad_err", r_err, 1);
        check("t5_bad_done", r_done, 0);
        check("t5_bad_busy", r_busy, 0);
        enable = 1'b0; clr_err = 1'b1;
        tick();
        enable = 1'b1; clr_err = 1'b0;
        check("t5_clr", r_err, 0);
        end_checks();

        // Reset in the middle of a 6-word packet.
        push_packet(2'b00, 6);
        repeat (3) tick();
        check("t6_ws_pre", r_ws, exp_ws - 4);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t6_busy", r_busy, 0);
        check("t6_ws", r_ws, 0);
        fifo_q.delete();
        exp_q.delete();
        exp_ws = 0; exp_done = 0; done_cnt = 0; exp_err = 1'b0;

        // enable low holds off the header pop.
        enable = 1'b0;
        push_packet(2'b10, 2);
        repeat (3) begin
            tick();
            check("t7_no_pop", c_rd, 0);
        end
        enable = 1'b1;
        run_until_idle(50);
        end_checks();

        // Randomized traffic with FIFO holes, backpressure and enable toggling.
        for (int round = 0; round < 3; round++) begin
            exp_err = 1'b0;
            rand_mode = 1'b1;
            for (int p = 0; p < 40; p++) begin
                case ($urandom_range(0, 6))
                    0, 1:    push_packet(2'b00, $urandom_range(0, 6));
                    2, 3:    push_packet(2'b10, $urandom_range(0, 6));
                    4, 5:    push_packet(2'b01, $urandom_range(0, 6));
                    default: push_packet(2'b11, $urandom_range(0, 6));
                endcase
            end
            run_until_idle(5000);
            rand_mode = 1'b0;
            enable = 1'b1;
            end_checks();
            check("rnd_err", r_err, exp_err);
            enable = 1'b0; clr_err = 1'b1;
            tick();
            enable = 1'b1; clr_err = 1'b0;
            check("rnd_err_clr", r_err, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
